// File: rtl/coin_input_conditioner.sv
// Conditions four bouncing coin-slot switches into clean single-cycle coin pulses,
// queued through a 4-deep FIFO and spaced by a minimum idle gap.
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000,
    parameter int GAP_CYCLES      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dollar_raw,
    input  logic       quarter_raw,
    input  logic       dime_raw,
    input  logic       nickel_raw,
    input  logic       enable,
    output logic       dollar,
    output logic       quarter,
    output logic       dime,
    output logic       nickel,
    output logic       reject,
    output logic       overflow,
    output logic [2:0] fifo_count,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  GAP_LOAD = 8'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

    // Channel index equals the coin code: 3=dollar, 2=quarter, 1=dime, 0=nickel.
    logic [3:0]  raw_vec;
    logic [3:0]  sync1, sync2, stable, stable_d;
    logic [15:0] db_cnt [4];
    logic [3:0]  coin_evt, accept, dup, set_mask, clr_mask, pending;

    logic [1:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        fifo_full, fifo_empty;
    logic        enq_valid, pop;
    logic [1:0]  enq_code, cur_code;

    state_t      state, state_next;
    logic [7:0]  gap_cnt, gap_next;

    assign raw_vec = {dollar_raw, quarter_raw, dime_raw, nickel_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= raw_vec;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Only rising stable levels are coins; a second coin on a still-pending channel is lost.
    assign coin_evt = stable & ~stable_d;
    assign accept   = enable ? coin_evt : 4'b0000;
    assign dup      = accept & pending;
    assign set_mask = accept & ~pending;

    assign fifo_full  = (count == 3'd4);
    assign fifo_empty = (count == 3'd0);
    assign pop        = (state == IDLE) && !fifo_empty && enable;

    always_comb begin
        enq_valid = 1'b0;
        enq_code  = 2'd0;
        if (!fifo_full) begin
            for (int i = 0; i < 4; i++) begin
                if (pending[i]) begin
                    enq_valid = 1'b1;
                    enq_code  = 2'(i);
                end
            end
        end
    end

    assign clr_mask = enq_valid ? (4'b0001 << enq_code) : 4'b0000;

    always_ff @(posedge clk) begin
        if (enq_valid) mem[wr_ptr] <= enq_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            reject   <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_mask) | set_mask;
            if (enq_valid) wr_ptr <= wr_ptr + 2'd1;
            if (pop)       rd_ptr <= rd_ptr + 2'd1;
            count    <= count + 3'(enq_valid) - 3'(pop);
            overflow <= overflow | (|dup);
            reject   <= (|coin_evt) & ~enable;
        end
    end

    // The IDLE cycle that issues the next pop counts as the final idle clock of the gap,
    // so back-to-back coins are separated by exactly GAP_CYCLES idle clocks.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        case (state)
            IDLE: begin
                if (pop) state_next = PULSE;
            end
            PULSE: begin
                if (GAP_CYCLES > 1) begin
                    state_next = GAP;
                    gap_next   = GAP_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_next = IDLE;
                else                 gap_next   = gap_cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            cur_code <= '0;
            dollar   <= 1'b0;
            quarter  <= 1'b0;
            dime     <= 1'b0;
            nickel   <= 1'b0;
        end else begin
            state    <= state_next;
            gap_cnt  <= gap_next;
            if (pop) cur_code <= mem[rd_ptr];
            dollar   <= (state == PULSE) && (cur_code == 2'd3);
            quarter  <= (state == PULSE) && (cur_code == 2'd2);
            dime     <= (state == PULSE) && (cur_code == 2'd1);
            nickel   <= (state == PULSE) && (cur_code == 2'd0);
        end
    end

    assign fifo_count = count;
    assign fsm_state  = state;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner with DEBOUNCE_CYCLES=4, GAP_CYCLES=2: expected pulses
// (code plus optional exact cycle) are queued when coins are inserted and matched by a monitor.
module tb_coin_input_conditioner;

    localparam int DB  = 4;
    localparam int GP  = 2;
    localparam int LAT = DB + 5;

    localparam logic [2:0] C_NICKEL  = 3'd0;
    localparam logic [2:0] C_DIME    = 3'd1;
    localparam logic [2:0] C_QUARTER = 3'd2;
    localparam logic [2:0] C_DOLLAR  = 3'd3;
    localparam logic [2:0] C_REJECT  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dollar_raw, quarter_raw, dime_raw, nickel_raw;
    logic       enable;
    logic       dollar, quarter, dime, nickel, reject, overflow;
    logic [2:0] fifo_count;
    logic [1:0] fsm_state;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          pulse_seen = 0;
    logic [18:0] exp_q[$];
    logic [3:0]  mon_hot;
    logic [2:0]  mon_code;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .GAP_CYCLES     (GP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dollar_raw (dollar_raw),
        .quarter_raw(quarter_raw),
        .dime_raw   (dime_raw),
        .nickel_raw (nickel_raw),
        .enable     (enable),
        .dollar     (dollar),
        .quarter    (quarter),
        .dime       (dime),
        .nickel     (nickel),
        .reject     (reject),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL global_timeout: cycle %0d, required finish before limit", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard: entry = {expected cycle (0 = any), code}
    task automatic push_exp(input int at_cyc, input logic [2:0] code);
        exp_q.push_back({16'(at_cyc), code});
    endtask

    task automatic sb_compare(input logic [2:0] code);
        logic [18:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(code), 32'd7);
        end else begin
            e = exp_q.pop_front();
            check("pulse_code", 32'(code), 32'(e[2:0]));
            if (e[18:3] != 16'd0) check("pulse_cycle", 32'(cyc), 32'(e[18:3]));
        end
    endtask

    always @(negedge clk) begin
        mon_hot = {dollar, quarter, dime, nickel};
        if (mon_hot != 4'b0000) begin
            pulse_seen++;
            check("one_hot", 32'($countones(mon_hot)), 32'd1);
            mon_code = dollar ? C_DOLLAR : quarter ? C_QUARTER : dime ? C_DIME : C_NICKEL;
            sb_compare(mon_code);
        end
        if (reject === 1'b1) sb_compare(C_REJECT);
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {dollar_raw, quarter_raw, dime_raw, nickel_raw} = v;
    endtask

    task automatic settle_low();
        set_raw(4'b0000);
        tick(DB + 8);
    endtask

    // Raises enable only for the clock on which coins sampled at edge k are accepted.
    task automatic enable_window(input int k);
        while (cyc < k + DB + 1) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int k0;
        int p0;

        rst    = 1'b1;
        enable = 1'b0;
        set_raw(4'b0000);
        tick(3);
        check("rst_pulses", 32'({dollar, quarter, dime, nickel, reject}), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0;
        tick(2);

        // single quarter
        enable = 1'b1;
        p0 = pulse_seen;
        k0 = cyc + 1;
        push_exp(k0 + LAT, C_QUARTER);
        set_raw(4'b0100);
        tick(20);
        set_raw(4'b0000);
        wait_drain(100);
        check("single_pulses", 32'(pulse_seen - p0), 32'd1);
        check("single_count", 32'(fifo_count), 32'd0);
        settle_low();

        // bouncing dime
        p0 = pulse_seen;
        set_raw(4'b0010); tick(2);
        set_raw(4'b0000); tick(2);
        set_raw(4'b0010); tick(2);
        set_raw(4'b0000); tick(2);
        k0 = cyc + 1;
        push_exp(k0 + LAT, C_DIME);
        set_raw(4'b0010);
        tick(20);
        set_raw(4'b0000);
        wait_drain(100);
        check("bounce_pulses", 32'(pulse_seen - p0), 32'd1);
        settle_low();

        // all four together: priority order, GP idle clocks between pulses
        k0 = cyc + 1;
        push_exp(k0 + LAT,                C_DOLLAR);
        push_exp(k0 + LAT + (GP + 1),     C_QUARTER);
        push_exp(k0 + LAT + 2 * (GP + 1), C_DIME);
        push_exp(k0 + LAT + 3 * (GP + 1), C_NICKEL);
        set_raw(4'b1111);
        tick(25);
        set_raw(4'b0000);
        wait_drain(100);
        check("simul_overflow", 32'(overflow), 32'd0);
        settle_low();

        // disabled: nickel is rejected
        enable = 1'b0;
        p0 = pulse_seen;
        k0 = cyc + 1;
        push_exp(k0 + DB + 2, C_REJECT);
        set_raw(4'b0001);
        tick(12);
        check("disabled_count", 32'(fifo_count), 32'd0);
        set_raw(4'b0000);
        wait_drain(100);
        check("disabled_pulses", 32'(pulse_seen - p0), 32'd0);
        settle_low();

        // fill FIFO, hold a pending quarter while full, then a duplicate quarter overflows
        p0 = pulse_seen;
        k0 = cyc + 1;
        set_raw(4'b1111);
        enable_window(k0);
        tick(6);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_no_pulse", 32'(pulse_seen - p0), 32'd0);
        settle_low();
        k0 = cyc + 1;
        push_exp(k0 + DB + 3, C_DOLLAR);
        set_raw(4'b1100);
        enable_window(k0);
        tick(6);
        check("held_count", 32'(fifo_count), 32'd4);
        check("held_overflow", 32'(overflow), 32'd0);
        settle_low();
        check("held_count_later", 32'(fifo_count), 32'd4);
        k0 = cyc + 1;
        push_exp(k0 + DB + 3, C_QUARTER);
        set_raw(4'b0100);
        enable_window(k0);
        tick(2);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_count", 32'(fifo_count), 32'd4);
        settle_low();
        push_exp(0, C_DIME);
        push_exp(0, C_NICKEL);
        push_exp(0, C_DOLLAR);
        push_exp(0, C_QUARTER);
        enable = 1'b1;
        wait_drain(100);
        check("full_total_pulses", 32'(pulse_seen - p0), 32'd6);
        check("full_drained", 32'(fifo_count), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // reset with three coins queued
        enable = 1'b0;
        k0 = cyc + 1;
        set_raw(4'b1110);
        enable_window(k0);
        tick(6);
        check("prerst_count", 32'(fifo_count), 32'd3);
        settle_low();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        p0 = pulse_seen;
        enable = 1'b1;
        tick(20);
        check("rst_mid_pulses", 32'(pulse_seen - p0), 32'd0);
        check("rst_mid_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
